// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon state type, controller FSM encoding and round limits.
package ascon_pkg;
  typedef logic [4:0][63:0] ascon_state_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} asconp_ctrl_state_e;
  localparam logic [3:0] ASCON_MAX_ROUNDS = 4'd12;
  localparam logic [3:0] ASCON_LAST_RND   = 4'd11;
endpackage

// File: rtl/asconp_round_ctrl.sv
// asconp_round_ctrl: iterative Ascon permutation round controller with valid/ready handshakes.
// Optional completed-permutation counter enabled by ASCONP_PERF_CNT_EN.
module asconp_round_ctrl
  import ascon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [3:0]       rounds_i,
  input  logic [63:0]      x0_i,
  input  logic [63:0]      x1_i,
  input  logic [63:0]      x2_i,
  input  logic [63:0]      x3_i,
  input  logic [63:0]      x4_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [63:0]      x0_o,
  output logic [63:0]      x1_o,
  output logic [63:0]      x2_o,
  output logic [63:0]      x3_o,
  output logic [63:0]      x4_o,
  output logic             busy_o,
  output logic [3:0]       round_cnt_o,
  output logic [63:0]      p_x0_o,
  output logic [63:0]      p_x1_o,
  output logic [63:0]      p_x2_o,
  output logic [63:0]      p_x3_o,
  output logic [63:0]      p_x4_o,
  input  logic [63:0]      p_x0_i,
  input  logic [63:0]      p_x1_i,
  input  logic [63:0]      p_x2_i,
  input  logic [63:0]      p_x3_i,
  input  logic [63:0]      p_x4_i
`ifdef ASCONP_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perm_cnt_o
`endif
);
  asconp_ctrl_state_e r_state, w_next;
  ascon_state_t       r_x;
  logic [3:0]         r_rnd;
  logic [3:0]         w_rounds;
  logic               w_last;
  // Out-of-range round requests fall back to the full p12 permutation.
  assign w_rounds = (rounds_i == 4'd0 || rounds_i > ASCON_MAX_ROUNDS) ? ASCON_MAX_ROUNDS : rounds_i;
  assign w_last   = r_rnd == ASCON_LAST_RND;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start_valid_i ? BUSY : IDLE;
      BUSY:    w_next = w_last ? DONE : BUSY;
      DONE:    w_next = done_ready_i ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    start_ready_o = r_state == IDLE;
    done_valid_o  = r_state == DONE;
    busy_o        = r_state != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x   <= '0;
      r_rnd <= '0;
    end else if (r_state == IDLE && start_valid_i) begin
      r_x   <= {x4_i, x3_i, x2_i, x1_i, x0_i};
      r_rnd <= ASCON_MAX_ROUNDS - w_rounds;
    end else if (r_state == BUSY) begin
      r_x   <= {p_x4_i, p_x3_i, p_x2_i, p_x1_i, p_x0_i};
      r_rnd <= w_last ? r_rnd : r_rnd + 4'd1;
    end else if (r_state == DONE && done_ready_i) begin
      r_rnd <= '0;
    end
  end
  assign {x4_o, x3_o, x2_o, x1_o, x0_o}           = r_x;
  assign {p_x4_o, p_x3_o, p_x2_o, p_x1_o, p_x0_o} = r_x;
  assign round_cnt_o = r_rnd;
`ifdef ASCONP_PERF_CNT_EN
  logic [CNT_W-1:0] r_perm_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_perm_cnt <= '0;
    else if (r_state == BUSY && w_last && r_perm_cnt != '1) r_perm_cnt <= r_perm_cnt + 1'b1;
  end
  assign perm_cnt_o = r_perm_cnt;
`else
  logic [CNT_W-1:0] w_unused_perf;
  assign w_unused_perf = '0;
`endif
endmodule

// File: tb/tb_asconp_round_ctrl.sv
// tb_asconp_round_ctrl: directed/random checks of the round controller against an Ascon model.
module tb_asconp_round_ctrl;
  import ascon_pkg::*;
  logic clk, rst_n, start_valid, start_ready, done_valid, done_ready, busy;
  logic [3:0] rounds, round_cnt;
  ascon_state_t x_in, x_out, p_out, p_in;
`ifdef ASCONP_PERF_CNT_EN
  logic [31:0] perm_cnt;
`endif
  int tests = 0, fails = 0, perms = 0;
  asconp_round_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .rounds_i(rounds),
    .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .x0_o(x_out[0]), .x1_o(x_out[1]), .x2_o(x_out[2]), .x3_o(x_out[3]), .x4_o(x_out[4]),
    .busy_o(busy), .round_cnt_o(round_cnt),
    .p_x0_o(p_out[0]), .p_x1_o(p_out[1]), .p_x2_o(p_out[2]), .p_x3_o(p_out[3]), .p_x4_o(p_out[4]),
    .p_x0_i(p_in[0]), .p_x1_i(p_in[1]), .p_x2_i(p_in[2]), .p_x3_i(p_in[3]), .p_x4_i(p_in[4])
`ifdef ASCONP_PERF_CNT_EN
    , .perm_cnt_o(perm_cnt)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  // One Ascon round with round index i (constant addition, S-box layer, linear layer).
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input int i);
    logic [63:0] x [5];
    logic [63:0] t [5];
    ascon_state_t r;
    for (int k = 0; k < 5; k++) x[k] = s[k];
    x[2] ^= {56'd0, 4'(15 - i), 4'(i)};
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
    for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    r[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
    r[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
    r[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
    r[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
    r[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    return r;
  endfunction
  // Combinational permutation datapath standing in for asconp_lut.
  always_comb p_in = ascon_round(p_out, int'(round_cnt));
  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction
  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_perm(input logic [3:0] r, input ascon_state_t s, input int hold);
    int n;
    ascon_state_t cur;
    n = (r == 0 || r > 12) ? 12 : int'(r);
    cur = s;
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1; rounds = r; x_in = s;
    @(negedge clk);
    start_valid = 0; x_in = rand_state();
    for (int k = 0; k < n; k++) begin
      chk("busy_flags", {busy, done_valid, start_ready}, 3'b100);
      chk("round_idx", round_cnt, 12 - n + k);
      chk("perm_input", p_out, cur);
      cur = ascon_round(cur, 12 - n + k);
      @(negedge clk);
    end
    chk("done_flags", {busy, done_valid, start_ready}, 3'b110);
    chk("result", x_out, cur);
    for (int k = 0; k < hold; k++) begin
      start_valid = (k == 3);
      rounds = 4'd1;
      x_in = rand_state();
      @(negedge clk);
      chk("hold_state", x_out, cur);
      chk("hold_flags", {done_valid, start_ready, busy}, 3'b101);
    end
    start_valid = 0; done_ready = 1;
    @(negedge clk);
    done_ready = 0;
    chk("release_flags", {busy, done_valid, start_ready}, 3'b001);
    chk("release_idx", round_cnt, 0);
    perms++;
  endtask
  initial begin
    ascon_state_t s;
    rst_n = 1; start_valid = 0; done_ready = 0; rounds = 0; x_in = '0;
    #1 rst_n = 0;
    #2;
    chk("reset_flags", {start_ready, done_valid, busy}, 3'b100);
    chk("reset_idx", round_cnt, 0);
    chk("reset_state", x_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_ready", start_ready, 1);
    chk("post_reset_idx", round_cnt, 0);
    run_perm(4'd12, '0, 0);
    s = rand_state();
    s[0] = 64'h80400c0600000000;
    run_perm(4'd6, s, 20);
    run_perm(4'd0, rand_state(), 0);
    run_perm(4'd15, rand_state(), 2);
    for (int j = 0; j < 6; j++) run_perm(4'($urandom_range(1, 12)), rand_state(), $urandom_range(0, 3));
    start_valid = 1; rounds = 4'd8; x_in = rand_state();
    @(negedge clk);
    start_valid = 0;
    repeat (4) @(negedge clk);
    chk("mid_round_idx", round_cnt, 8);
    #2 rst_n = 0;
    #1;
    perms = 0;
    chk("midrst_flags", {start_ready, done_valid, busy}, 3'b100);
    chk("midrst_idx", round_cnt, 0);
    chk("midrst_state", x_out, 0);
`ifdef ASCONP_PERF_CNT_EN
    chk("midrst_perm_cnt", perm_cnt, perms);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) run_perm(4'($urandom_range(1, 12)), rand_state(), 0);
`ifdef ASCONP_PERF_CNT_EN
    chk("perm_cnt", perm_cnt, perms);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
